// File: rtl/progress_wd_pkg.sv
// Shared types and constants for the multi-channel progress watchdog.
package progress_wd_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    BASELINE = 3'd1,
    RUN      = 3'd2,
    WARN     = 3'd3,
    EXPIRED  = 3'd4
  } wd_state_t;

  localparam int unsigned MODE_VALUE  = 0;
  localparam int unsigned MODE_STROBE = 1;
  localparam int unsigned MODE_EITHER = 2;

endpackage

// File: rtl/progress_wd_chan.sv
// One watchdog channel: progress detection, stall counter, warn/expiry FSM
// and the value latched at expiry.
module progress_wd_chan
  import progress_wd_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned THRESH      = 1000000,
  parameter int unsigned WARN_THRESH = 0,
  parameter int unsigned MODE        = MODE_VALUE,
  parameter int unsigned CNT_W       = $clog2(THRESH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm,
  input  logic             clear,
  input  logic [XLEN-1:0]  value,
  input  logic             prog_valid,
  output logic             warn,
  output logic             expired,
  output logic [CNT_W-1:0] cnt,
  output logic [XLEN-1:0]  stuck
);

  // A disabled warning level collapses onto THRESH, which the expiry branch claims first.
  localparam int unsigned WARN_LVL = (WARN_THRESH == 0) ? THRESH : WARN_THRESH;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] WARN_C   = CNT_W'(WARN_LVL);

  wd_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  prev_q, prev_d;
  logic [XLEN-1:0]  stuck_q, stuck_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             val_chg;
  logic             progress;

  always_comb begin
    val_chg = (value != prev_q);
    unique case (MODE)
      MODE_VALUE:  progress = val_chg;
      MODE_STROBE: progress = prog_valid;
      default:     progress = val_chg | prog_valid;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    stuck_d = stuck_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (clear) begin
      state_d = arm ? BASELINE : DISARMED;
      cnt_d   = '0;
      stuck_d = '0;
    end else begin
      unique case (state_q)
        DISARMED: begin
          cnt_d = '0;
          if (arm) state_d = BASELINE;
        end
        BASELINE: begin
          prev_d  = value;
          cnt_d   = '0;
          state_d = arm ? RUN : DISARMED;
        end
        RUN, WARN: begin
          if (!arm) begin
            state_d = DISARMED;
            cnt_d   = '0;
          end else begin
            prev_d = value;
            if (progress) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == THRESH_C) begin
                state_d = EXPIRED;
                stuck_d = value;
              end else if (cnt_inc >= WARN_C) begin
                state_d = WARN;
              end else begin
                state_d = RUN;
              end
            end
          end
        end
        EXPIRED: cnt_d = THRESH_C;
        default: begin
          state_d = DISARMED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= DISARMED;
      cnt_q   <= '0;
      prev_q  <= '0;
      stuck_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      stuck_q <= stuck_d;
    end
  end

  assign warn    = (state_q == WARN);
  assign expired = (state_q == EXPIRED);
  assign cnt     = cnt_q;
  assign stuck   = stuck_q;

endmodule

// File: rtl/progress_watchdog_mc.sv
// Multi-channel hang detector: per-channel watchdogs plus first-expired
// priority encode, stuck-value select and peak counter reduction.
module progress_watchdog_mc
  import progress_wd_pkg::*;
#(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned THRESH      = 1000000,
  parameter int unsigned WARN_THRESH = 0,
  parameter int unsigned MODE        = MODE_VALUE,
  parameter int unsigned CNT_W       = $clog2(THRESH + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               arm,
  input  logic [NUM_CH-1:0]               clear,
  input  logic [NUM_CH*XLEN-1:0]          value,
  input  logic [NUM_CH-1:0]               prog_valid,
  output logic [NUM_CH-1:0]               warn_vec,
  output logic [NUM_CH-1:0]               expired_vec,
  output logic                            timeout,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] timeout_ch,
  output logic [XLEN-1:0]                 stuck_value,
  output logic [CNT_W-1:0]                max_count
);

  localparam int unsigned TCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0] cnt_arr   [NUM_CH];
  logic [XLEN-1:0]  stuck_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    progress_wd_chan #(
      .XLEN        (XLEN),
      .THRESH      (THRESH),
      .WARN_THRESH (WARN_THRESH),
      .MODE        (MODE),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .arm        (arm[i]),
      .clear      (clear[i]),
      .value      (value[i*XLEN +: XLEN]),
      .prog_valid (prog_valid[i]),
      .warn       (warn_vec[i]),
      .expired    (expired_vec[i]),
      .cnt        (cnt_arr[i]),
      .stuck      (stuck_arr[i])
    );
  end

  assign timeout = |expired_vec;

  // Descending scan so the lowest expired index is the last writer.
  always_comb begin
    timeout_ch  = '0;
    stuck_value = '0;
    max_count   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (expired_vec[i]) begin
        timeout_ch  = TCH_W'(i);
        stuck_value = stuck_arr[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_arr[i] > max_count) max_count = cnt_arr[i];
    end
  end

endmodule
